// File: rtl/slot_alloc_ctrl_pkg.sv
// Shared sizing helpers and slot index type for the slot allocator and the pool storage behind it.
// Default pool geometry lives here so storage and allocator agree on widths.
package slot_alloc_ctrl_pkg;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_NUM_ENTRY = 16;

    function automatic int idx_width(input int num_entry);
        return (num_entry > 1) ? $clog2(num_entry) : 1;
    endfunction

    function automatic int cnt_width(input int num_entry);
        return $clog2(num_entry + 1);
    endfunction

    function automatic int lane_width(input int num_req);
        return $clog2(num_req) + 1;
    endfunction

    localparam int DEF_IDX_W  = idx_width(DEF_NUM_ENTRY);
    localparam int DEF_CNT_W  = cnt_width(DEF_NUM_ENTRY);
    localparam int DEF_LANE_W = lane_width(DEF_NUM_REQ);

    typedef logic [DEF_IDX_W-1:0] slot_idx_t;

endpackage

// File: rtl/slot_alloc_ctrl_prefix_sum.sv
// Inclusive prefix sum: sums[i] = data[0] + ... + data[i], each result OUTPUT_SIZE bits wide.
module prefix_sum #(
    parameter int NUM_INPUT   = 4,
    parameter int INPUT_SIZE  = 1,
    parameter int OUTPUT_SIZE = 3
) (
    input  logic [NUM_INPUT*INPUT_SIZE-1:0]  data,
    output logic [NUM_INPUT*OUTPUT_SIZE-1:0] sums
);

    function automatic logic [NUM_INPUT*OUTPUT_SIZE-1:0] scan(
        input logic [NUM_INPUT*INPUT_SIZE-1:0] d
    );
        logic [OUTPUT_SIZE-1:0]           acc;
        logic [NUM_INPUT*OUTPUT_SIZE-1:0] res;
        acc = '0;
        res = '0;
        for (int i = 0; i < NUM_INPUT; i++) begin
            acc = acc + OUTPUT_SIZE'(d[i*INPUT_SIZE +: INPUT_SIZE]);
            res[i*OUTPUT_SIZE +: OUTPUT_SIZE] = acc;
        end
        return res;
    endfunction

    assign sums = scan(data);

endmodule

// File: rtl/slot_alloc_ctrl.sv
// In-order multi-lane allocator for a circular slot pool; grants the oldest requesting lanes that fit.
// Optional `define ALLOC_FLUSH_EN adds a flush input that empties the pool in one cycle.
module slot_alloc_ctrl
    import slot_alloc_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int NUM_ENTRY = DEF_NUM_ENTRY,
    parameter int IDX_W     = idx_width(NUM_ENTRY),
    parameter int CNT_W     = cnt_width(NUM_ENTRY),
    parameter int LANE_W    = lane_width(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef ALLOC_FLUSH_EN
    input  logic                     flush,
`endif
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_grant,
    output logic [NUM_REQ*IDX_W-1:0] req_idx,
    input  logic [LANE_W-1:0]        rel_cnt,
    output logic [IDX_W-1:0]         head_idx,
    output logic [CNT_W-1:0]         free_cnt,
    output logic                     full,
    output logic                     empty
);

    localparam logic [CNT_W-1:0] ENTRY_CNT = CNT_W'(NUM_ENTRY);

    logic [IDX_W-1:0]          head;
    logic [IDX_W-1:0]          tail;
    logic [CNT_W-1:0]          occ;
    logic [CNT_W-1:0]          free_q;
    logic                      full_q;
    logic                      empty_q;

    logic [NUM_REQ*LANE_W-1:0] incl_flat;
    logic [LANE_W-1:0]         incl [NUM_REQ];
    logic [LANE_W-1:0]         excl [NUM_REQ];
    logic                      hold;
    logic [LANE_W-1:0]         n_alloc;
    logic [CNT_W-1:0]          rel_ext;
    logic [CNT_W-1:0]          n_rel;
    logic [CNT_W-1:0]          occ_next;
    logic [IDX_W-1:0]          head_next;
    logic [IDX_W-1:0]          tail_next;

    prefix_sum #(
        .NUM_INPUT   (NUM_REQ),
        .INPUT_SIZE  (1),
        .OUTPUT_SIZE (LANE_W)
    ) u_scan (
        .data (req_valid),
        .sums (incl_flat)
    );

`ifdef ALLOC_FLUSH_EN
    assign hold = rst || flush;
`else
    assign hold = rst;
`endif

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            incl[i] = incl_flat[i*LANE_W +: LANE_W];
            excl[i] = incl[i] - LANE_W'(req_valid[i]);
        end
    end

    // Grant stage: incl is monotonic, so the last granted lane's incl is also the grant count.
    always_comb begin
        req_grant = '0;
        req_idx   = '0;
        n_alloc   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_idx[i*IDX_W +: IDX_W] = tail + IDX_W'(excl[i]);
            if (req_valid[i] && (CNT_W'(incl[i]) <= free_q) && !hold) begin
                req_grant[i] = 1'b1;
                n_alloc      = incl[i];
            end
        end
    end

    // A release larger than the occupancy is clamped so head never passes tail.
    always_comb begin
        rel_ext   = CNT_W'(rel_cnt);
        n_rel     = (rel_ext > occ) ? occ : rel_ext;
        occ_next  = occ + CNT_W'(n_alloc) - n_rel;
        head_next = head + IDX_W'(n_rel);
        tail_next = tail + IDX_W'(n_alloc);
    end

    // State stage: free/full/empty are registered alongside occ to keep them off the grant path.
    always_ff @(posedge clk) begin
        if (rst) begin
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            free_q  <= ENTRY_CNT;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
`ifdef ALLOC_FLUSH_EN
        end else if (flush) begin
            tail    <= head;
            occ     <= '0;
            free_q  <= ENTRY_CNT;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
`endif
        end else begin
            head    <= head_next;
            tail    <= tail_next;
            occ     <= occ_next;
            free_q  <= ENTRY_CNT - occ_next;
            full_q  <= (occ_next == ENTRY_CNT);
            empty_q <= (occ_next == '0);
        end
    end

    assign head_idx = head;
    assign free_cnt = free_q;
    assign full     = full_q;
    assign empty    = empty_q;

endmodule

// File: tb/tb_slot_alloc_ctrl.sv
// Scoreboard bench for slot_alloc_ctrl: directed pool scenarios followed by a random run.
module tb_slot_alloc_ctrl;
    import slot_alloc_ctrl_pkg::*;

    localparam int NR = DEF_NUM_REQ;
    localparam int NE = DEF_NUM_ENTRY;
    localparam int IW = DEF_IDX_W;
    localparam int CW = DEF_CNT_W;
    localparam int LW = DEF_LANE_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_grant;
    logic [NR*IW-1:0] req_idx;
    logic [LW-1:0]    rel_cnt;
    logic [IW-1:0]    head_idx;
    logic [CW-1:0]    free_cnt;
    logic             full;
    logic             empty;
`ifdef ALLOC_FLUSH_EN
    logic             flush;
`endif

    always #5 clk = ~clk;

    slot_alloc_ctrl dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ALLOC_FLUSH_EN
        .flush     (flush),
`endif
        .req_valid (req_valid),
        .req_grant (req_grant),
        .req_idx   (req_idx),
        .rel_cnt   (rel_cnt),
        .head_idx  (head_idx),
        .free_cnt  (free_cnt),
        .full      (full),
        .empty     (empty)
    );

    typedef struct {
        logic [NR-1:0]    grant;
        logic [NR*IW-1:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   m_head, m_tail, m_occ;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive, predict, check the combinational grant, then check state after the edge.
    task automatic step(input logic r, input logic f, input logic [NR-1:0] v, input int rel);
        exp_t e;
        exp_t got;
        int   cnt, free, n_alloc, n_rel;
        @(negedge clk);
        rst       = r;
        req_valid = v;
        rel_cnt   = rel[LW-1:0];
`ifdef ALLOC_FLUSH_EN
        flush     = f;
`endif
        free    = NE - m_occ;
        cnt     = 0;
        n_alloc = 0;
        e.grant = '0;
        e.idx   = '0;
        for (int i = 0; i < NR; i++) begin
            e.idx[i*IW +: IW] = IW'((m_tail + cnt) % NE);
            if (v[i]) begin
                cnt++;
                if (!r && !f && cnt <= free) begin
                    e.grant[i] = 1'b1;
                    n_alloc++;
                end
            end
        end
        exp_q.push_back(e);

        #1;
        got = exp_q.pop_front();
        chk("grant", 32'(req_grant), 32'(got.grant));
        chk("idx", 32'(req_idx), 32'(got.idx));

        if (r) begin
            m_head = 0; m_tail = 0; m_occ = 0;
        end else if (f) begin
            m_tail = m_head; m_occ = 0;
        end else begin
            n_rel  = (rel > m_occ) ? m_occ : rel;
            m_tail = (m_tail + n_alloc) % NE;
            m_head = (m_head + n_rel) % NE;
            m_occ  = m_occ + n_alloc - n_rel;
        end

        @(posedge clk);
        #1;
        chk("head_idx", 32'(head_idx), 32'(m_head));
        chk("free_cnt", 32'(free_cnt), 32'(NE - m_occ));
        chk("full", 32'(full), 32'(m_occ == NE));
        chk("empty", 32'(empty), 32'(m_occ == 0));
    endtask

    initial begin
        logic fl;
        m_head = 0; m_tail = 0; m_occ = 0;
        rst = 1'b1; req_valid = '0; rel_cnt = '0;
`ifdef ALLOC_FLUSH_EN
        flush = 1'b0;
`endif
        // Reset with requests pending: nothing is granted
        step(1'b1, 1'b0, 4'b1111, 0);
        chk("rst_free", 32'(free_cnt), 32'd16);

        // Four lanes from an empty pool
        step(1'b0, 1'b0, 4'b1111, 0);
        chk("fill4_free", 32'(free_cnt), 32'd12);
        step(1'b0, 1'b0, 4'b0001, 0);
        // Gapped request from tail 5
        step(1'b0, 1'b0, 4'b1010, 0);

        // Partial fit: bring free down to 2, then request 4 while releasing 3
        step(1'b0, 1'b0, 4'b1111, 0);
        step(1'b0, 1'b0, 4'b0111, 0);
        chk("pf_free", 32'(free_cnt), 32'd2);
        step(1'b0, 1'b0, 4'b1111, 3);
        chk("pf_after", 32'(free_cnt), 32'd3);

        // Fill to full, request while full, release while full
        step(1'b0, 1'b0, 4'b1111, 0);
        step(1'b0, 1'b0, 4'b1111, 0);
        chk("full_flag", 32'(full), 32'd1);
        step(1'b0, 1'b0, 4'b1111, 4);

        // Wrap case: reset, park tail at 14 with occ 0, then allocate 4
        step(1'b1, 1'b0, 4'b0000, 0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'b1111, 0);
        step(1'b0, 1'b0, 4'b0011, 0);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'b0000, 4);
        chk("wrap_empty", 32'(empty), 32'd1);
        // Release on an empty pool is ignored
        step(1'b0, 1'b0, 4'b0000, 4);
        chk("empty_head", 32'(head_idx), 32'd14);
        step(1'b0, 1'b0, 4'b1111, 0);

        // Mid-run reset with requests pending
        step(1'b0, 1'b0, 4'b1111, 1);
        step(1'b1, 1'b0, 4'b1111, 2);
        chk("midrst_head", 32'(head_idx), 32'd0);

`ifdef ALLOC_FLUSH_EN
        step(1'b0, 1'b0, 4'b1111, 0);
        step(1'b0, 1'b0, 4'b0111, 1);
        step(1'b0, 1'b1, 4'b1111, 2);
        chk("flush_free", 32'(free_cnt), 32'd16);
`endif

        // Random traffic
        for (int k = 0; k < 300; k++) begin
            fl = 1'b0;
`ifdef ALLOC_FLUSH_EN
            fl = ($urandom_range(0, 19) == 0);
`endif
            step(($urandom_range(0, 49) == 0), fl, NR'($urandom), $urandom_range(0, NR));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
